aes_inv_cipher_iter: RTL and testbench

Iterative AES inverse cipher (decryptor): accepts one 128-bit ciphertext block and a Nk-word key over a valid/ready handshake, executes one decryption round per clock, and returns the 128-bit plaintext over a second valid/ready handshake. It is the receive-side counterpart of the combinational `cipher` encryptor. It reuses the existing `KeyExpansion` and `AddRoundKey` blocks, so both directions share the same key schedule and byte ordering.

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/AddRoundKey.sv | 8 +
 rtl/KeyExpansion.sv | 37 +++
 rtl/inv_round.sv | 38 +++
 rtl/aes_inv_cipher_iter.sv | 110 +++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 228 ++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: FSM state type, GF(2^8) multipliers, and forward/inverse
// S-box tables built at elaboration from field arithmetic.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_fsm_e;
  typedef logic [255:0][7:0] sbox_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Multiplicative inverse from exp/log tables over generator 03, then the affine map.
  function automatic sbox_t gen_sbox();
    sbox_t exp_t, log_t, t;
    logic [7:0] p, v;
    exp_t = '0;
    log_t = '0;
    t     = '0;
    p     = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = p;
      log_t[p] = 8'(i);
      p        = p ^ xtime(p);
    end
    for (int x = 0; x < 256; x++) begin
      v    = (x == 0) ? 8'h00 : exp_t[(255 - int'(log_t[x])) % 255];
      t[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
    return t;
  endfunction

  function automatic sbox_t gen_inv_sbox(input sbox_t s);
    sbox_t t;
    t = '0;
    for (int x = 0; x < 256; x++) t[s[x]] = 8'(x);
    return t;
  endfunction

  localparam sbox_t SBOX     = gen_sbox();
  localparam sbox_t INV_SBOX = gen_inv_sbox(SBOX);

  function automatic int nk_to_nr(input int nk);
    return nk + 6;
  endfunction

endpackage

// File: rtl/AddRoundKey.sv
// AddRoundKey: XOR of the 128-bit state with one round key.
module AddRoundKey (
  input  logic [127:0] state_i,
  input  logic [127:0] rkey_i,
  output logic [127:0] state_o
);
  assign state_o = state_i ^ rkey_i;
endmodule

// File: rtl/KeyExpansion.sv
// KeyExpansion: combinational AES key schedule for Nk = 4/6/8.
// Key word 0 sits in the top bits; round key i is Word[128*i +: 128], first word on top.
module KeyExpansion import aes_pkg::*; #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic [32*Nk-1:0]      Key,
  output logic [128*(Nr+1)-1:0] Word
);
  localparam int NW = 4 * (Nr + 1);

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  always_comb begin : p_expand
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0]  rc;
    w    = '{default: 32'h0};
    t    = '0;
    rc   = 8'h01;
    Word = '0;
    for (int i = 0; i < Nk; i++) w[i] = Key[32*(Nk-1-i) +: 32];
    for (int i = Nk; i < NW; i++) begin
      t = w[i-1];
      if (i % Nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (Nk > 6 && i % Nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-Nk] ^ t;
    end
    for (int r = 0; r <= Nr; r++) Word[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end
endmodule

// File: rtl/inv_round.sv
// inv_round: one combinational AES inverse round; 'last' bypasses InvMixColumns.
module inv_round import aes_pkg::*; (
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);
  logic [127:0] sr, ark, mc;
  logic [7:0]   a [4];

  // Byte k = 4*col + row lives at bits [127-8k -: 8]; row r rotates right by r.
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = INV_SBOX[state_in[127-8*(4*((c-r+4)%4)+r) -: 8]];
  end

  AddRoundKey u_ark (
    .state_i (sr),
    .rkey_i  (round_key),
    .state_o (ark)
  );

  always_comb begin
    mc = '0;
    a  = '{default: 8'h00};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = ark[127-8*(4*c+r) -: 8];
      mc[127-8*(4*c)   -: 8] = mul0e(a[0]) ^ mul0b(a[1]) ^ mul0d(a[2]) ^ mul09(a[3]);
      mc[127-8*(4*c+1) -: 8] = mul09(a[0]) ^ mul0e(a[1]) ^ mul0b(a[2]) ^ mul0d(a[3]);
      mc[127-8*(4*c+2) -: 8] = mul0d(a[0]) ^ mul09(a[1]) ^ mul0e(a[2]) ^ mul0b(a[3]);
      mc[127-8*(4*c+3) -: 8] = mul0b(a[0]) ^ mul0d(a[1]) ^ mul09(a[2]) ^ mul0e(a[3]);
    end
  end

  assign state_out = last ? ark : mc;
endmodule

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES decryptor, one inverse round per clock.
// Define AES_INV_ZEROIZE_EN to clear state, key and output registers on the output handshake.
module aes_inv_cipher_iter import aes_pkg::*; #(
  parameter int Nb = 4,
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in,
  input  logic [32*Nk-1:0] Key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out,
  output logic             busy
);
  localparam int CW = $clog2(Nr);

  if (Nb != 4 || !(Nk == 4 || Nk == 6 || Nk == 8) || Nr != nk_to_nr(Nk)) begin : g_bad_cfg
    $error("aes_inv_cipher_iter: unsupported Nb/Nk/Nr combination");
  end

  aes_fsm_e                fsm_q, fsm_d;
  logic [32*Nk-1:0]        key_q, key_d;
  logic [127:0]            st_q, st_d;
  logic [127:0]            out_q, out_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [32*Nk-1:0]        ks_key;
  logic [128*(Nr+1)-1:0]   word;
  logic [127:0]            rk, rnd_out;

  // In IDLE the schedule runs from the input key so w[Nr] is ready at the accept edge.
  assign ks_key = (fsm_q == IDLE) ? Key : key_q;

  KeyExpansion #(.Nk(Nk), .Nr(Nr)) u_kexp (
    .Key  (ks_key),
    .Word (word)
  );

  assign rk = word[128*int'(cnt_q) +: 128];

  inv_round u_round (
    .state_in  (st_q),
    .round_key (rk),
    .last      (cnt_q == '0),
    .state_out (rnd_out)
  );

  always_comb begin
    fsm_d     = fsm_q;
    key_d     = key_q;
    st_d      = st_q;
    out_d     = out_q;
    cnt_d     = cnt_q;
    in_ready  = (fsm_q == IDLE);
    out_valid = (fsm_q == DONE);
    busy      = (fsm_q == ROUND) || (fsm_q == DONE);
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          key_d = Key;
          st_d  = in ^ word[128*Nr +: 128];
          cnt_d = CW'(Nr - 1);
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        st_d = rnd_out;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          out_d = rnd_out;
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
`ifdef AES_INV_ZEROIZE_EN
          st_d  = '0;
          key_d = '0;
          out_d = '0;
`else
`endif
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      key_q <= '0;
      st_q  <= '0;
      out_q <= '0;
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      key_q <= key_d;
      st_q  <= st_d;
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign out = out_q;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: AES-128/192/256 instances checked with known answers
// and random blocks produced by a forward-cipher reference model.
module tb_aes_inv_cipher_iter;
  localparam int NU = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NU-1:0] in_valid = '0, out_ready = '0;
  logic [NU-1:0] in_ready, out_valid, busy;
  logic [127:0]  din [NU];
  logic [127:0]  dout [NU];
  logic [127:0]  k128 = '0;
  logic [191:0]  k192 = '0;
  logic [255:0]  k256 = '0;
  int            nr_of [NU] = '{10, 12, 14};
  int            nk_of [NU] = '{4, 6, 8};
  int            n_cmp = 0, n_err = 0;
  logic [7:0]    sb [256];

  aes_inv_cipher_iter #(.Nk(4), .Nr(10)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in(din[0]),
    .Key(k128), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out(dout[0]), .busy(busy[0]));
  aes_inv_cipher_iter #(.Nk(6), .Nr(12)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in(din[1]),
    .Key(k192), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out(dout[1]), .busy(busy[1]));
  aes_inv_cipher_iter #(.Nk(8), .Nr(14)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in(din[2]),
    .Key(k256), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out(dout[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box by brute-force field inverse and the bitwise affine formula.
  task automatic build_sbox();
    logic [7:0] v, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      v = '0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [255:0] key, input int nk);
    int nr;
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   n [16];
    logic [127:0] res;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = key[224-32*i +: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
          rc = gm(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int k = 0; k < 16; k++) s[k] = pt[120-8*k +: 8] ^ w[k/4][24-8*(k%4) +: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sb[s[k]];
      for (int c = 0; c < 4; c++) for (int j = 0; j < 4; j++) n[4*c+j] = s[4*((c+j)%4)+j];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gm(n[4*c], 8'h02) ^ gm(n[4*c+1], 8'h03) ^ n[4*c+2] ^ n[4*c+3];
          s[4*c+1] = n[4*c] ^ gm(n[4*c+1], 8'h02) ^ gm(n[4*c+2], 8'h03) ^ n[4*c+3];
          s[4*c+2] = n[4*c] ^ n[4*c+1] ^ gm(n[4*c+2], 8'h02) ^ gm(n[4*c+3], 8'h03);
          s[4*c+3] = gm(n[4*c], 8'h03) ^ n[4*c+1] ^ n[4*c+2] ^ gm(n[4*c+3], 8'h02);
        end
      end else s = n;
      for (int k = 0; k < 16; k++) s[k] ^= w[4*r + k/4][24-8*(k%4) +: 8];
    end
    for (int k = 0; k < 16; k++) res[120-8*k +: 8] = s[k];
    return res;
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_key(input int u, input logic [255:0] key);
    case (u)
      0:       k128 = key[255:128];
      1:       k192 = key[255:64];
      default: k256 = key;
    endcase
  endtask

  // One block: accept, noise during rounds, latency/result checks, stall, handshake.
  task automatic run_block(input int u, input logic [127:0] ct, input logic [255:0] key,
                           input logic [127:0] pt, input int hold, input string tag);
    int n;
    logic [127:0] idle_exp;
    @(negedge clk);
    chk({tag, ".rdy"}, 128'(in_ready[u]), 128'd1);
    din[u] = ct;
    set_key(u, key);
    in_valid[u] = 1'b1;
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    n = 0;
    while (!out_valid[u] && n < 40) begin
      din[u] = r128();
      set_key(u, {r128(), r128()});
      in_valid[u]  = 1'($urandom);
      out_ready[u] = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b0;
    chk({tag, ".lat"}, 128'(n), 128'(nr_of[u]));
    chk({tag, ".out"}, dout[u], pt);
    chk({tag, ".busy"}, 128'(busy[u]), 128'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_out"}, dout[u], pt);
      chk({tag, ".hold_vld"}, 128'(out_valid[u]), 128'd1);
      chk({tag, ".hold_rdy"}, 128'(in_ready[u]), 128'd0);
    end
    out_ready[u] = 1'b1;
    @(negedge clk);
    chk({tag, ".hs_rdy"}, 128'(in_ready[u]), 128'd0);
    @(posedge clk); #1;
    out_ready[u] = 1'b0;
`ifdef AES_INV_ZEROIZE_EN
    idle_exp = '0;
`else
    idle_exp = pt;
`endif
    chk({tag, ".post_vld"}, 128'(out_valid[u]), 128'd0);
    chk({tag, ".post_rdy"}, 128'(in_ready[u]), 128'd1);
    chk({tag, ".post_busy"}, 128'(busy[u]), 128'd0);
    chk({tag, ".post_out"}, dout[u], idle_exp);
  endtask

  localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] pt, ct;
    logic [255:0] key;
    int u;
    for (int i = 0; i < NU; i++) din[i] = '0;
    build_sbox();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NU; i++) begin
      chk($sformatf("rst%0d.rdy", i), 128'(in_ready[i]), 128'd1);
      chk($sformatf("rst%0d.vld", i), 128'(out_valid[i]), 128'd0);
      chk($sformatf("rst%0d.busy", i), 128'(busy[i]), 128'd0);
      chk($sformatf("rst%0d.out", i), dout[i], 128'd0);
    end
    @(negedge clk) rst_n = 1'b1;

    run_block(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, PT0, 0, "kat128");
    run_block(1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
              {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, PT0, 1, "kat192");
    run_block(2, 128'h8ea2b7ca516745bfeafc49904b496089,
              256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, PT0, 0, "kat256");
    run_block(0, 128'h3925841d02dc09fbdc118597196a0b32,
              {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
              128'h3243f6a8885a308d313198a2e0370734, 5, "loop");

    // Abort mid-round with an asynchronous reset.
    @(negedge clk);
    din[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    k128   = 128'h000102030405060708090a0b0c0d0e0f;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort.pre_busy", 128'(busy[0]), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.vld", 128'(out_valid[0]), 128'd0);
    chk("abort.rdy", 128'(in_ready[0]), 128'd1);
    chk("abort.busy", 128'(busy[0]), 128'd0);
    chk("abort.out", dout[0], 128'd0);
    @(negedge clk) rst_n = 1'b1;
    run_block(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, PT0, 0, "after_rst");

    for (int t = 0; t < 9; t++) begin
      u   = t % NU;
      pt  = r128();
      key = {r128(), r128()};
      ct  = encrypt(pt, key, nk_of[u]);
      run_block(u, ct, key, pt, int'($urandom_range(0, 3)), $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
